// File: rtl/usart_tx_sched.sv
// Round-robin transmit scheduler in front of usart_ctrl: requesters push bytes into a small FIFO,
// and an issuer emits one write command per byte, spaced by a fixed byte time.
module usart_tx_sched #(
    parameter int         NUM_REQ     = 2,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         BYTE_CYCLES = 1390,
    parameter logic [2:0] CMD_TX      = 3'd2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   usart_write,
    output logic [2:0]             usart_cmd,
    output logic [7:0]             usart_data,
    output logic                   busy
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int RRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW  = $clog2(BYTE_CYCLES);

    localparam logic [CW-1:0]  FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [RRW-1:0] RR_LAST    = RRW'(NUM_REQ - 1);
    localparam logic [HW-1:0]  HOLD_LOAD  = HW'(BYTE_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t         state_q, state_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [RRW-1:0] rr_q, rr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           write_q, write_d;
    logic [2:0]     cmd_q, cmd_d;
    logic [7:0]     data_q, data_d;
    logic [7:0]     mem_q [FIFO_DEPTH];

    logic [7:0]         lane [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [RRW-1:0]     grant_idx;
    logic               push;
    logic               pop;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Search starts at rr and wraps; a full FIFO (or reset) blocks every grant.
    always_comb begin
        int             idx;
        logic [RRW-1:0] idx_l;
        grant     = '0;
        grant_idx = '0;
        push      = 1'b0;
        idx       = 0;
        idx_l     = '0;
        if (!reset && count_q != FULL_COUNT) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                idx_l = RRW'(idx);
                if (!push && req_valid[idx_l]) begin
                    grant[idx_l] = 1'b1;
                    grant_idx    = idx_l;
                    push         = 1'b1;
                end
            end
        end
    end

    assign req_ready = grant;

    always_comb begin
        pop      = (state_q == ISSUE);
        rr_d     = rr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            rr_d     = (grant_idx == RR_LAST) ? '0 : grant_idx + 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = HOLD;
                hold_d  = HOLD_LOAD;
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = (count_q != '0) ? ISSUE : IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with ISSUE exactly.
        write_d = (state_d == ISSUE);
        cmd_d   = write_d ? CMD_TX : 3'd0;
        data_d  = write_d ? mem_q[rd_ptr_q] : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            write_q  <= 1'b0;
            cmd_q    <= 3'd0;
            data_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            write_q  <= write_d;
            cmd_q    <= cmd_d;
            data_q   <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= lane[grant_idx];
        end
    end

    assign usart_write = write_q;
    assign usart_cmd   = cmd_q;
    assign usart_data  = data_q;
    assign busy        = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_usart_tx_sched.sv
// Directed bench for usart_tx_sched: two requesters, 4-deep FIFO, 8-cycle byte time.
module tb_usart_tx_sched;

    localparam int NR = 2;
    localparam int FD = 4;
    localparam int BC = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [8*NR-1:0]   req_data;
    logic [NR-1:0]     req_ready;
    logic              usart_write;
    logic [2:0]        usart_cmd;
    logic [7:0]        usart_data;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {int cyc; int req; logic [7:0] data;} xfer_t;
    typedef struct {int cyc; logic [7:0] data;} wr_t;
    xfer_t xq[$];
    wr_t   wq[$];

    usart_tx_sched #(
        .NUM_REQ(NR), .FIFO_DEPTH(FD), .BYTE_CYCLES(BC), .CMD_TX(3'd2)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .usart_write(usart_write), .usart_cmd(usart_cmd),
        .usart_data(usart_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Logs write pulses and accepted transfers; checks idle outputs and one-hot grant every cycle.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (usart_write === 1'b1) begin
                wq.push_back('{cyc, usart_data});
                chk("wr_cmd", 32'(usart_cmd), 32'd2);
            end else begin
                chk("idle_write", 32'(usart_write), 32'd0);
                chk("idle_cmd", 32'(usart_cmd), 32'd0);
                chk("idle_data", 32'(usart_data), 32'd0);
            end
            chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    xq.push_back('{cyc, i, req_data[8*i +: 8]});
                end
            end
        end
    end

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic pstep();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) nstep();
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        int k = 0;
        while (wq.size() < n && k < budget) begin
            nstep();
            k++;
        end
        chk(tag, 32'(wq.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        nstep();
        while (busy !== 1'b0 && k < 200) begin
            nstep();
            k++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        pstep();
        reset     = 1'b1;
        req_valid = '0;
        pstep();
        reset = 1'b0;
        xq.delete();
        wq.delete();
    endtask

    task automatic send_bytes(input logic [7:0] first, input logic [7:0] step, input int n);
        int         sent  = 0;
        int         guard = 0;
        logic       take;
        logic [7:0] b = first;
        pstep();
        req_data[7:0] = b;
        req_valid     = 2'b01;
        while (sent < n && guard < 200) begin
            nstep();
            take = req_ready[0];
            pstep();
            if (take) begin
                sent++;
                b = b + step;
                req_data[7:0] = b;
            end
            guard++;
        end
        req_valid = '0;
        chk("send_done", sent, n);
    endtask

    initial begin
        int         p;
        int         off [6];
        logic [7:0] e;

        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        pstep();
        req_valid = 2'b11;
        nstep();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_write", 32'(usart_write), 32'd0);
        pstep();
        req_valid = '0;
        reset     = 1'b0;
        xq.delete();
        wq.delete();

        // Single byte: 2-cycle latency, busy drops one byte time after the pulse.
        send_bytes(8'h41, 8'h00, 1);
        nstep();
        chk("t1_busy_early", 32'(busy), 32'd1);
        wait_writes(1, 20, "t1_write_seen");
        chk("t1_xfers", xq.size(), 1);
        chk("t1_data", 32'(wq[0].data), 32'h41);
        chk("t1_latency", wq[0].cyc - xq[0].cyc, 2);
        p = wq[0].cyc;
        wait_until(p + BC - 1);
        chk("t1_busy_hold", 32'(busy), 32'd1);
        wait_until(p + BC);
        chk("t1_busy_fall", 32'(busy), 32'd0);
        chk("t1_one_pulse", wq.size(), 1);

        // Contention: grants alternate, pulses BC apart, FIFO order preserved.
        do_reset();
        req_data  = {8'h31, 8'h30};
        req_valid = 2'b11;
        wait_writes(4, 80, "t2_writes_seen");
        pstep();
        req_valid = '0;
        wait_idle("t2_idle");
        chk("t2_latency", wq[0].cyc - xq[0].cyc, 2);
        for (int k = 0; k < 4; k++) begin
            e = 8'h30 + 8'(k % 2);
            chk("t2_grant", xq[k].req, k % 2);
            chk("t2_wdata", 32'(wq[k].data), 32'(e));
            if (k > 0) chk("t2_gap", wq[k].cyc - wq[k-1].cyc, BC);
        end
        chk("t2_count", wq.size(), xq.size());
        for (int k = 0; k < wq.size(); k++) chk("t2_order", 32'(wq[k].data), 32'(xq[k].data));

        // Backpressure: five back-to-back accepts, stall until the second pop, in-order issue.
        do_reset();
        send_bytes(8'h01, 8'h01, 6);
        wait_idle("t3_idle");
        off = '{0, 1, 2, 3, 4, 11};
        chk("t3_xfers", xq.size(), 6);
        chk("t3_writes", wq.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk("t3_accept_cyc", xq[k].cyc - xq[0].cyc, off[k]);
            chk("t3_wdata", 32'(wq[k].data), k + 1);
            chk("t3_write_cyc", wq[k].cyc - xq[0].cyc, 2 + BC * k);
        end

        // Fairness under full: grant after the stall goes to the requester after the last one.
        do_reset();
        req_data  = {8'hB1, 8'hA0};
        req_valid = 2'b11;
        wait_writes(8, 120, "t4_writes_seen");
        pstep();
        req_valid = '0;
        wait_idle("t4_idle");
        chk("t4_stall", xq[5].cyc - xq[4].cyc, 7);
        chk("t4_after_stall", xq[5].req, 1);
        for (int k = 0; k < 8; k++) begin
            chk("t4_grant", xq[k].req, k % 2);
            chk("t4_order", 32'(wq[k].data), 32'(xq[k].data));
        end

        // Reset during HOLD: queued bytes discarded, then normal latency for a fresh byte.
        do_reset();
        send_bytes(8'h11, 8'h11, 3);
        wait_writes(1, 20, "t5_first_seen");
        p = wq[0].cyc;
        wait_until(p + 3);
        pstep();
        reset = 1'b1;
        pstep();
        reset = 1'b0;
        nstep();
        chk("t5_write_after_rst", 32'(usart_write), 32'd0);
        chk("t5_busy_after_rst", 32'(busy), 32'd0);
        repeat (30) nstep();
        chk("t5_no_stale", wq.size(), 1);
        chk("t5_first_data", 32'(wq[0].data), 32'h11);
        wq.delete();
        xq.delete();
        send_bytes(8'h5A, 8'h00, 1);
        wait_writes(1, 20, "t5_new_seen");
        chk("t5_new_data", 32'(wq[0].data), 32'h5A);
        chk("t5_new_latency", wq[0].cyc - xq[0].cyc, 2);
        wait_idle("t5_idle");

        // Idle gap: no spurious writes; pacing restarts from the new request.
        wq.delete();
        xq.delete();
        repeat (20) nstep();
        chk("t6_no_spurious", wq.size(), 0);
        chk("t6_busy_idle", 32'(busy), 32'd0);
        send_bytes(8'h77, 8'h00, 1);
        wait_writes(1, 20, "t6_seen");
        chk("t6_data", 32'(wq[0].data), 32'h77);
        chk("t6_latency", wq[0].cyc - xq[0].cyc, 2);
        wait_idle("t6_idle");
        chk("t6_one_pulse", wq.size(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
